// File: rtl/clk_div_pkg.sv
// Shared definitions for the fixed-ratio clock dividers and their phase monitor.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_MEAS = 2'd2
    } mon_state_e;

    localparam int DIV6_HIGH = 6;
    localparam int DIV6_LOW  = 6;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
        return (value >= limit) ? limit : value + 32'd1;
    endfunction

endpackage

// File: rtl/clk_phase_runlen.sv
// Two-flop sampler of the divided clock with edge detect and a saturating
// run-length counter of how long the older sample has held its level.
module clk_phase_runlen
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_div,
    output logic             o_edge,
    output logic             o_level,
    output logic [CNT_W-1:0] o_run
);
    localparam logic [31:0] RUN_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic             r_s_q;
    logic             r_s_qq;
    logic [CNT_W-1:0] r_run;
    logic             w_edge;

    assign w_edge = (r_s_q != r_s_qq);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s_q  <= 1'b0;
            r_s_qq <= 1'b0;
            r_run  <= '0;
        end else begin
            r_s_q  <= i_div;
            r_s_qq <= r_s_q;
            if (i_clr) begin
                r_run <= '0;
            end else if (w_edge) begin
                r_run <= CNT_W'(1);
            end else begin
                r_run <= CNT_W'(sat_inc(32'(r_run), RUN_MAX));
            end
        end
    end

    assign o_edge  = w_edge;
    assign o_level = r_s_qq;
    assign o_run   = r_run;

endmodule

// File: rtl/clk_div_monitor.sv
// Checks every high/low phase of a same-domain divided clock against its
// expected length; reports lock, error pulse/sticky and last measured phases.
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int HIGH_CYC    = DIV6_HIGH,
    parameter int LOW_CYC     = DIV6_LOW,
    parameter int TOL         = 0,
    parameter int LOCK_PHASES = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] high_meas,
    output logic [CNT_W-1:0] low_meas
);
    localparam int GOOD_W = $clog2(LOCK_PHASES + 1);

    mon_state_e        r_state;
    mon_state_e        w_state_next;
    logic              w_edge;
    logic              w_level;
    logic              w_run_clr;
    logic [CNT_W-1:0]  w_run;
    int                w_run_i;
    int                w_exp;
    logic              w_in_tol;
    logic              w_check;
    logic              w_timeout;
    logic              w_err;
    logic [GOOD_W-1:0] w_good_inc;

    logic              r_to_fired;
    logic [GOOD_W-1:0] r_good;
    logic              r_locked;
    logic              r_err_pulse;
    logic              r_err_sticky;
    logic [CNT_W-1:0]  r_high_meas;
    logic [CNT_W-1:0]  r_low_meas;

    // Run length is meaningless outside acquisition/measurement, so hold it at 0.
    assign w_run_clr = !en || (r_state == ST_IDLE);

    clk_phase_runlen #(
        .CNT_W (CNT_W)
    ) u_runlen (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_run_clr),
        .i_div   (div_in),
        .o_edge  (w_edge),
        .o_level (w_level),
        .o_run   (w_run)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!en) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_ACQ;
                ST_ACQ:  if (w_edge) w_state_next = ST_MEAS;
                ST_MEAS: w_state_next = ST_MEAS;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_run_i    = int'(w_run);
        w_exp      = w_level ? HIGH_CYC : LOW_CYC;
        w_in_tol   = (w_run_i >= w_exp - TOL) && (w_run_i <= w_exp + TOL);
        w_check    = en && (r_state == ST_MEAS) && w_edge;
        // Level has outlived its longest legal length; report it once per run.
        w_timeout  = en && (r_state == ST_MEAS) && !w_edge && !r_to_fired
                     && (w_run_i == w_exp + TOL + 1);
        w_err      = (w_check && !w_in_tol) || w_timeout;
        w_good_inc = GOOD_W'(sat_inc(32'(r_good), 32'(LOCK_PHASES)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_fired   <= 1'b0;
            r_good       <= '0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_high_meas  <= '0;
            r_low_meas   <= '0;
        end else begin
            r_err_pulse <= w_err;

            if (!en || (r_state != ST_MEAS) || w_edge) begin
                r_to_fired <= 1'b0;
            end else if (w_timeout) begin
                r_to_fired <= 1'b1;
            end

            if (w_err) begin
                r_err_sticky <= 1'b1;
            end else if (clr_err) begin
                r_err_sticky <= 1'b0;
            end

            if (w_check) begin
                if (w_level) begin
                    r_high_meas <= w_run;
                end else begin
                    r_low_meas <= w_run;
                end
            end

            if (!en || (r_state == ST_IDLE) || w_err) begin
                r_good   <= '0;
                r_locked <= 1'b0;
            end else if (w_check) begin
                r_good <= w_good_inc;
                if (w_good_inc == GOOD_W'(LOCK_PHASES)) begin
                    r_locked <= 1'b1;
                end
            end
        end
    end

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_err_sticky;
    assign high_meas  = r_high_meas;
    assign low_meas   = r_low_meas;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Drives two monitors (TOL=0 and TOL=1) with a shared divided clock and checks
// them each cycle against a phase-level model, plus hand-computed spot values.
module tb_clk_div_monitor;
    localparam int CNT_W = 8;
    localparam int LOCK  = 8;

    typedef struct {
        int high_cyc;
        int low_cyc;
        int tol;
        bit d1;
        bit d2;
        int len2;
        bit en_active;
        bit meas;
        bit fired;
        int good;
        bit locked;
        bit pulse;
        bit sticky;
        int hmeas;
        int lmeas;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic div_in = 1'b0;
    logic clr_err = 1'b0;

    logic             locked0, pulse0, sticky0;
    logic [CNT_W-1:0] high0, low0;
    logic             locked1, pulse1, sticky1;
    logic [CNT_W-1:0] high1, low1;

    int n_checks = 0;
    int n_errors = 0;
    int pulses0 = 0;
    int pulses1 = 0;
    model_t m0, m1;

    clk_div_monitor #(
        .HIGH_CYC(6), .LOW_CYC(6), .TOL(0), .LOCK_PHASES(LOCK), .CNT_W(CNT_W)
    ) dut0 (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in), .clr_err(clr_err),
        .locked(locked0), .err_pulse(pulse0), .err_sticky(sticky0),
        .high_meas(high0), .low_meas(low0)
    );

    clk_div_monitor #(
        .HIGH_CYC(6), .LOW_CYC(6), .TOL(1), .LOCK_PHASES(LOCK), .CNT_W(CNT_W)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in), .clr_err(clr_err),
        .locked(locked1), .err_pulse(pulse1), .err_sticky(sticky1),
        .high_meas(high1), .low_meas(low1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset(inout model_t m, input int tol);
        m = '{default: 0};
        m.high_cyc = 6;
        m.low_cyc  = 6;
        m.tol      = tol;
    endfunction

    // Phase-level reference: a level sampled at consecutive edges forms a phase;
    // its completion is reported one edge after the change of level is sampled.
    function automatic void model_step(inout model_t m, input bit en_n, input bit clr, input bit din);
        bit boundary;
        bit active;
        bit err;
        int exp_len;
        boundary = (m.d1 != m.d2);
        active   = en_n && m.meas;
        exp_len  = m.d2 ? m.high_cyc : m.low_cyc;
        err      = 1'b0;
        if (active && boundary) begin
            if (m.d2) m.hmeas = m.len2;
            else      m.lmeas = m.len2;
            if (m.len2 < exp_len - m.tol || m.len2 > exp_len + m.tol) begin
                err = 1'b1;
            end else begin
                if (m.good < LOCK) m.good++;
                if (m.good == LOCK) m.locked = 1'b1;
            end
        end
        if (boundary || !active) begin
            m.fired = 1'b0;
        end else if (!m.fired && m.len2 == exp_len + m.tol + 1) begin
            err     = 1'b1;
            m.fired = 1'b1;
        end
        m.pulse = err;
        if (err) begin
            m.sticky = 1'b1;
            m.good   = 0;
            m.locked = 1'b0;
        end else if (clr) begin
            m.sticky = 1'b0;
        end
        if (!en_n) begin
            m.good   = 0;
            m.locked = 1'b0;
        end
        // The first boundary seen after enabling only marks where measuring starts.
        if (!en_n) begin
            m.en_active = 1'b0;
            m.meas      = 1'b0;
        end else if (!m.en_active) begin
            m.en_active = 1'b1;
        end else if (boundary) begin
            m.meas = 1'b1;
        end
        if (m.d1 == m.d2) m.len2 = (m.len2 < 255) ? m.len2 + 1 : 255;
        else              m.len2 = 1;
        m.d2 = m.d1;
        m.d1 = din;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset(m0, 0);
            model_reset(m1, 1);
        end else begin
            model_step(m0, en, clr_err, div_in);
            model_step(m1, en, clr_err, div_in);
        end
    end

    task automatic cmp(input string tag, input model_t m, input logic lk, input logic pu,
                       input logic st, input logic [CNT_W-1:0] hi, input logic [CNT_W-1:0] lo);
        check({tag, "_locked"},     32'(lk), 32'(m.locked));
        check({tag, "_err_pulse"},  32'(pu), 32'(m.pulse));
        check({tag, "_err_sticky"}, 32'(st), 32'(m.sticky));
        check({tag, "_high_meas"},  32'(hi), 32'(m.hmeas));
        check({tag, "_low_meas"},   32'(lo), 32'(m.lmeas));
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            cmp("dut0", m0, locked0, pulse0, sticky0, high0, low0);
            cmp("dut1", m1, locked1, pulse1, sticky1, high1, low1);
            if (pulse0 === 1'b1) pulses0++;
            if (pulse1 === 1'b1) pulses1++;
        end
    end

    task automatic hold(input logic lvl, input int n);
        $display("drive div_in=%0d for %0d cycles en=%0d clr_err=%0d", lvl, n, en, clr_err);
        for (int k = 0; k < n; k++) begin
            div_in = lvl;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pairs(input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    task automatic pulse_clr(input logic lvl);
        clr_err = 1'b1;
        hold(lvl, 1);
        clr_err = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int p1;
        logic lvl;
        int len;

        repeat (3) @(negedge clk);
        #1;
        check("rst_locked", 32'(locked0), 32'd0);
        check("rst_sticky", 32'(sticky0), 32'd0);
        check("rst_high", 32'(high0), 32'd0);

        // Ideal 6/6 divider; 8th good phase completes 48 clk after the first edge.
        rst = 1'b1;
        en  = 1'b1;
        pairs(4, 6, 6);
        hold(1'b1, 1);
        check("lock_early", 32'(locked0), 32'd0);
        hold(1'b1, 1);
        check("lock_on_time", 32'(locked0), 32'd1);
        check("lock_on_time_tol1", 32'(locked1), 32'd1);
        check("ideal_high", 32'(high0), 32'd6);
        check("ideal_low", 32'(low0), 32'd6);
        check("ideal_sticky", 32'(sticky0), 32'd0);
        hold(1'b1, 4);
        hold(1'b0, 6);
        pairs(1, 6, 6);

        // Short high phase, clr_err coinciding with the error.
        hold(1'b1, 5);
        hold(1'b0, 1);
        clr_err = 1'b1;
        hold(1'b0, 1);
        clr_err = 1'b0;
        check("short_pulse", 32'(pulse0), 32'd1);
        check("short_sticky_set_wins", 32'(sticky0), 32'd1);
        check("short_unlock", 32'(locked0), 32'd0);
        check("short_high_meas", 32'(high0), 32'd5);
        check("short_tol1_locked", 32'(locked1), 32'd1);
        hold(1'b0, 1);
        check("short_pulse_ends", 32'(pulse0), 32'd0);
        hold(1'b0, 3);
        pulse_clr(1'b1);
        check("clr_alone", 32'(sticky0), 32'd0);
        hold(1'b1, 5);
        hold(1'b0, 6);
        pairs(5, 6, 6);
        check("relock", 32'(locked0), 32'd1);

        // Stuck high: exactly one timeout per stuck run, meas untouched.
        p0 = pulses0;
        p1 = pulses1;
        hold(1'b1, 30);
        check("stuck_one_pulse", 32'(pulses0 - p0), 32'd1);
        check("stuck_one_pulse_tol1", 32'(pulses1 - p1), 32'd1);
        check("stuck_high_meas", 32'(high0), 32'd6);
        check("stuck_sticky", 32'(sticky0), 32'd1);
        hold(1'b0, 6);
        pulse_clr(1'b1);
        check("clr_after_stuck", 32'(sticky1), 32'd0);
        hold(1'b1, 5);
        hold(1'b0, 6);
        pairs(5, 6, 6);

        // 7/5 phases: inside TOL=1, outside TOL=0; then an 8 breaks TOL=1.
        pairs(6, 7, 5);
        check("tol1_locked", 32'(locked1), 32'd1);
        check("tol1_no_err", 32'(sticky1), 32'd0);
        check("tol1_high", 32'(high1), 32'd7);
        check("tol1_low", 32'(low1), 32'd5);
        check("tol0_err", 32'(sticky0), 32'd1);
        hold(1'b1, 8);
        hold(1'b0, 2);
        check("tol1_err8", 32'(sticky1), 32'd1);
        check("tol1_unlock8", 32'(locked1), 32'd0);
        check("tol1_high8", 32'(high1), 32'd8);
        hold(1'b0, 4);

        // Drop enable mid-phase: no error for the partial phase, lock lost.
        pairs(6, 6, 6);
        hold(1'b1, 3);
        p0 = pulses0;
        p1 = pulses1;
        en = 1'b0;
        hold(1'b1, 1);
        check("en_drop_unlock", 32'(locked0), 32'd0);
        check("en_drop_unlock_tol1", 32'(locked1), 32'd0);
        hold(1'b1, 2);
        en = 1'b1;
        hold(1'b1, 2);
        hold(1'b0, 6);
        pairs(2, 6, 6);
        check("en_drop_no_err", 32'(pulses0 - p0), 32'd0);
        check("en_drop_no_err_tol1", 32'(pulses1 - p1), 32'd0);

        // Asynchronous reset mid-measurement, then recovery.
        pairs(6, 6, 6);
        check("lock_before_rst", 32'(locked0), 32'd1);
        hold(1'b1, 3);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_locked", 32'(locked0), 32'd0);
        check("async_rst_sticky", 32'(sticky0), 32'd0);
        check("async_rst_pulse", 32'(pulse0), 32'd0);
        check("async_rst_high", 32'(high0), 32'd0);
        check("async_rst_low", 32'(low0), 32'd0);
        check("async_rst_locked_tol1", 32'(locked1), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        hold(1'b1, 3);
        hold(1'b0, 6);
        pairs(6, 6, 6);
        check("relock_after_rst", 32'(locked0), 32'd1);

        // Randomised phases with occasional enable drops, clears and stuck runs.
        lvl = 1'b1;
        for (int i = 0; i < 200; i++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 20) : $urandom_range(4, 8);
            en  = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) begin
                pulse_clr(lvl);
                hold(lvl, len - 1);
            end else begin
                hold(lvl, len);
            end
            lvl = ~lvl;
        end

        en = 1'b1;
        hold(1'b0, 4);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Downstream checker for the fixed-ratio clock dividers. It samples a divided clock produced on the same clk domain, measures every high and low phase in clk cycles, and compares each against expected lengths. It reports lock, per-phase errors, a sticky error flag and the last measured phase lengths, so divider faults are caught in system without a scope.

Parameters:
HIGH_CYC, 6, expected high-phase length in clk cycles (>=1)
LOW_CYC, 6, expected low-phase length in clk cycles (>=1)
TOL, 0, allowed +/- deviation per phase in cycles
LOCK_PHASES, 8, consecutive good phases required to assert locked (>=1)
CNT_W, 8, width of run counter and measurement outputs; must hold max(HIGH_CYC,LOW_CYC)+TOL+1

Ports:
clk  in  1  system clock; the divider under test runs on this clock
rst  in  1  asynchronous, active-low reset
en  in  1  monitor enable; 0 forces IDLE
div_in  in  1  divided clock under test, synchronous to clk
clr_err  in  1  one-cycle pulse, clears err_sticky
locked  out  1  LOCK_PHASES consecutive in-tolerance phases seen, no error since
err_pulse  out  1  one-cycle pulse per detected error
err_sticky  out  1  set on any error, held until clr_err
high_meas  out  CNT_W  length of last completed high phase
low_meas  out  CNT_W  length of last completed low phase

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, run counter 0, sample registers 0, good-phase counter 0.
- Sampling: s_q <= div_in; s_qq <= s_q. Edge exists when s_q != s_qq; the completed phase level is s_qq.
- Run counter: on edge, run <= 1. Otherwise run <= run+1, saturating at all-ones. run equals the cycles s_qq has held its level.
- FSM states are IDLE, ACQ and MEAS.
  - IDLE: entered on en=0 from any state. Clears run, good count and locked. Keeps err_sticky, high_meas and low_meas. When en=1, go to ACQ.
  - ACQ: waits for the first edge and discards the partial first phase without checking it. On that edge, go to MEAS.
  - MEAS: on each edge, check the completed phase. If s_qq=1, write run to high_meas and compare against HIGH_CYC. If s_qq=0, write run to low_meas and compare against LOW_CYC.
- Good phase: EXP-TOL <= run <= EXP+TOL. It increments the good count, which saturates at LOCK_PHASES. locked <= 1 when the count reaches LOCK_PHASES, on the same edge as that measurement update.
- Bad phase: err_pulse=1 for one cycle, err_sticky <= 1, locked <= 0, good count <= 0.
- Stuck timeout: in MEAS with no edge, if run == EXP(s_q)+TOL+1, flag an error once with the same effect as a bad phase. Meas registers are unchanged. No further timeout fires during the same run.
- Latency: a div_in transition sampled at clk edge k updates the meas registers, err_pulse and locked at edge k+1.
- clr_err and a new error in the same cycle: set wins, so err_sticky stays 1.
- en falling during MEAS: IDLE on the next edge. Any phase in progress is discarded and no error is flagged.
- Mid-operation reset: everything returns to reset values immediately. Acquisition restarts from ACQ after release when en=1.

Decomposition:
- Shared package clk_div_pkg holds:
  - the state enum (IDLE/ACQ/MEAS);
  - a saturating-increment function;
  - the default divider ratio constants (DIV6_HIGH=6, DIV6_LOW=6), so dividers and this monitor share one source.
- One sub-module, clk_phase_runlen, contains the two sample flops, the edge detect and the saturating run counter. It outputs edge, level and run.

Test Plan:
- Ideal divider, 6 high / 6 low, en=1: no error. high_meas=low_meas=6. locked rises on the 8th edge after the first edge after enable, i.e. 48 clk after the first edge.
- After lock, shorten one high phase to 5: err_pulse one cycle, err_sticky=1, locked=0, high_meas=5. Lock re-acquires after 8 further good phases.
- Hold div_in high indefinitely (TOL=0): single err_pulse when run reaches 7. No second pulse during the stuck run. Meas unchanged.
- TOL=1, phases of 7 and 5: no error, locked. A phase of 8 produces an error.
- Assert clr_err in the same cycle as an error: err_sticky stays 1. A later clr_err alone clears it to 0.
- Drop en mid-phase, then raise it again: locked=0 and the partial phase is ignored. Then assert rst mid-MEAS: all outputs 0 asynchronously, and the block recovers to lock after release.
